aes_cipher_serializer: RTL and testbench

Downstream stage of the AES core. Captures each 128-bit ciphertext block when the core flags completion, buffers up to two blocks, and streams them out one byte per transfer over a valid/ready byte interface (toward a UART/host link). Absorbs sink back-pressure so a stalled consumer never corrupts a block in flight.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_block_buf2.sv | 61 ++++++
 rtl/aes_cipher_serializer.sv | 67 ++++++
 tb/tb_aes_cipher_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES widths and the byte-index-to-slice convention used by the core,
// the upstream loader and the ciphertext serializer.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned AES_BYTES   = 16;

    // Byte 0 is the first AES state byte and sits in the top bits of the block.
    function automatic logic [AES_BYTE_W-1:0] aes_byte(input logic [AES_BLOCK_W-1:0] blk,
                                                       input logic [3:0] idx);
        return blk[AES_BLOCK_W - 1 - AES_BYTE_W * int'(idx) -: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/aes_block_buf2.sv
// Two-entry ping-pong block buffer with write/read pointers, occupancy count and
// a sticky overflow flag for blocks dropped while full.
module aes_block_buf2
    import aes_pkg::*;
#(
    parameter int unsigned BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic               pop,
    output logic [BLOCK_W-1:0] rdata,
    output logic [1:0]         count,
    output logic               overflow
);

    logic [BLOCK_W-1:0] mem_q [2];
    logic               wp_q, rp_q;
    logic [1:0]         count_q;
    logic               overflow_q;
    logic               accept;

    // A pop in the same cycle frees the entry being written when full.
    assign accept = push && ((count_q != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wp_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wp_q <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            if (push && !accept) begin
                overflow_q <= 1'b1;
            end
            if (accept && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !accept) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign rdata    = mem_q[rp_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/aes_cipher_serializer.sv
// Captures AES ciphertext blocks into a two-entry buffer and streams them out
// one byte per valid/ready transfer, byte 0 first.
module aes_cipher_serializer
    import aes_pkg::*;
#(
    parameter int unsigned BLOCK_W = AES_BLOCK_W,
    parameter int unsigned BYTE_W  = AES_BYTE_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] text,
    input  logic               text_valid,
    output logic [BYTE_W-1:0]  byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               byte_last,
    output logic               busy,
    output logic               overflow,
    output logic [CNT_W-1:0]   blocks_sent
);

    logic [BLOCK_W-1:0] rdata;
    logic [1:0]         count;
    logic [3:0]         idx_q;
    logic [CNT_W-1:0]   blocks_sent_q;
    logic               xfer;
    logic               pop;

    assign xfer = byte_valid && byte_ready;
    assign pop  = xfer && (idx_q == 4'd15);

    aes_block_buf2 #(
        .BLOCK_W (BLOCK_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (text_valid),
        .wdata    (text),
        .pop      (pop),
        .rdata    (rdata),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= 4'd0;
            blocks_sent_q <= '0;
        end else begin
            if (xfer) begin
                idx_q <= idx_q + 4'd1;
            end
            if (pop && (blocks_sent_q != '1)) begin
                blocks_sent_q <= blocks_sent_q + CNT_W'(1);
            end
        end
    end

    // Gated with valid so the output reads zero while the buffer is empty.
    assign byte_valid  = (count != 2'd0);
    assign busy        = byte_valid;
    assign byte_last   = byte_valid && (idx_q == 4'd15);
    assign byte_out    = byte_valid ? aes_byte(rdata, idx_q) : '0;
    assign blocks_sent = blocks_sent_q;

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// Directed self-checking bench for aes_cipher_serializer.
module tb_aes_cipher_serializer;

    logic         clk;
    logic         reset;
    logic [127:0] text;
    logic         text_valid;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready;
    logic         byte_last;
    logic         busy;
    logic         overflow;
    logic [15:0]  blocks_sent;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] BLK_K = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BLK_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BLK_B = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;

    aes_cipher_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .text        (text),
        .text_valid  (text_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_last   (byte_last),
        .busy        (busy),
        .overflow    (overflow),
        .blocks_sent (blocks_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bref(input logic [127:0] b, input int i);
        logic [127:0] t;
        t = b >> (8 * (15 - i));
        return t[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] blk);
        text       = blk;
        text_valid = 1'b1;
        tick();
        text_valid = 1'b0;
    endtask

    // Expects 16 consecutive accepted bytes of blk; byte_ready must be high.
    task automatic expect_block(input string tag, input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_valid"}, 32'(byte_valid), 32'd1);
            check({tag, "_byte"}, 32'(byte_out), 32'(bref(blk, i)));
            check({tag, "_last"}, 32'(byte_last), 32'(i == 15));
            tick();
        end
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        text       = '0;
        text_valid = 1'b0;
        byte_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_last", 32'(byte_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte", 32'(byte_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_sent", 32'(blocks_sent), 32'd0);

        // Single block, sink always ready; first byte the cycle after capture
        byte_ready = 1'b1;
        push(BLK_K);
        expect_block("single", BLK_K);
        check("single_busy", 32'(busy), 32'd0);
        check("single_sent", 32'(blocks_sent), 32'd1);

        // Back-pressure with ready pattern 1,0,0,1
        byte_ready = 1'b0;
        push(BLK_K);
        k = 0;
        for (int c = 0; c < 64 && k < 16; c++) begin
            byte_ready = ((c % 4) == 0) || ((c % 4) == 3);
            check("bp_valid", 32'(byte_valid), 32'd1);
            check("bp_byte", 32'(byte_out), 32'(bref(BLK_K, k)));
            check("bp_last", 32'(byte_last), 32'(k == 15));
            tick();
            if (byte_ready) k++;
        end
        check("bp_count", 32'(k), 32'd16);
        check("bp_busy", 32'(busy), 32'd0);
        check("bp_sent", 32'(blocks_sent), 32'd2);

        // Two blocks captured while stalled, then drained back-to-back
        byte_ready = 1'b0;
        push(BLK_A);
        push(BLK_B);
        check("two_busy", 32'(busy), 32'd1);
        check("two_byte0", 32'(byte_out), 32'h00);
        byte_ready = 1'b1;
        expect_block("twoA", BLK_A);
        expect_block("twoB", BLK_B);
        check("two_ovf", 32'(overflow), 32'd0);
        check("two_busy_end", 32'(busy), 32'd0);
        check("two_sent", 32'(blocks_sent), 32'd4);

        // Overflow: third block dropped while full
        byte_ready = 1'b0;
        push(BLK_K);
        push(BLK_A);
        check("ovf_pre", 32'(overflow), 32'd0);
        push(BLK_B);
        check("ovf_set", 32'(overflow), 32'd1);
        byte_ready = 1'b1;
        expect_block("ovf1", BLK_K);
        expect_block("ovf2", BLK_A);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_sent", 32'(blocks_sent), 32'd6);

        // Reset clears sticky overflow and the counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_ovf", 32'(overflow), 32'd0);
        check("rst2_sent", 32'(blocks_sent), 32'd0);

        // Push coinciding with the final pop while full
        byte_ready = 1'b0;
        push(BLK_A);
        push(BLK_B);
        byte_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("pp_byte", 32'(byte_out), 32'(bref(BLK_A, i)));
            tick();
        end
        check("pp_last", 32'(byte_last), 32'd1);
        check("pp_byte15", 32'(byte_out), 32'(bref(BLK_A, 15)));
        push(BLK_K);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_busy", 32'(busy), 32'd1);
        expect_block("ppB", BLK_B);
        expect_block("ppK", BLK_K);
        check("pp_busy_end", 32'(busy), 32'd0);
        check("pp_ovf_end", 32'(overflow), 32'd0);
        check("pp_sent", 32'(blocks_sent), 32'd3);

        // Reset mid-block discards the block in flight
        push(BLK_A);
        for (int i = 0; i < 5; i++) begin
            check("mid_byte", 32'(byte_out), 32'(bref(BLK_A, i)));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid", 32'(byte_valid), 32'd0);
        check("mid_byte_rst", 32'(byte_out), 32'd0);
        check("mid_sent", 32'(blocks_sent), 32'd0);
        check("mid_ovf", 32'(overflow), 32'd0);
        push(BLK_B);
        expect_block("mid_next", BLK_B);
        check("mid_sent_end", 32'(blocks_sent), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
